// File: rtl/div_iter_if.sv
// Start/done handshake between the execute stage and the iterative divider.
// The execute stage drives the operands; the divider returns the result and flags.
interface div_iter_if #(
    parameter int N = 64
);
    logic             start;
    logic [N-1:0]     dividend;
    logic [N/2-1:0]   divisor;
    logic             busy;
    logic             done;
    logic [N/2-1:0]   q;
    logic [N/2-1:0]   r;
    logic             dz;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, q, r, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, q, r, dz, ovf
    );
endinterface

// File: rtl/div_iter.sv
// Restoring unsigned divider, N-bit dividend by N/2-bit divisor, one quotient bit per cycle.
// Divide-by-zero and quotient overflow are resolved at accept time without iterating.
module div_iter #(
    parameter int N = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    div_iter_if.slave  bus
);
    localparam int H  = N / 2;
    localparam int CW = $clog2(H + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    // The top bit of R is always zero between iterations (R < divisor), so only H bits are kept.
    logic [H-1:0]  rem_q, rem_d;
    logic [H-1:0]  sh_q, sh_d;
    logic [H-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [H-1:0]  q_q, q_d;
    logic [H-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic [H:0]    trial;
    logic          ge;
    logic [H-1:0]  rem_nxt;
    logic [H-1:0]  sh_nxt;
    logic [H-1:0]  hi;
    logic [H-1:0]  lo;

    assign hi = bus.dividend[N-1:H];
    assign lo = bus.dividend[H-1:0];

    always_comb begin
        trial   = {rem_q, sh_q[H-1]};
        ge      = trial >= {1'b0, dvs_q};
        // Low H bits of the difference are exact because the result is below the divisor.
        rem_nxt = ge ? (trial[H-1:0] - dvs_q) : trial[H-1:0];
        sh_nxt  = {sh_q[H-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        q_d     = '1;
                        r_d     = lo;
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (hi >= bus.divisor) begin
                        q_d     = '1;
                        r_d     = lo;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = hi;
                        sh_d    = lo;
                        dvs_d   = bus.divisor;
                        cnt_d   = CW'(H);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nxt;
                sh_d  = sh_nxt;
                cnt_d = cnt_q - 1'b1;
                // Results are published only on entry to DONE so they stay stable while iterating.
                if (cnt_q == CW'(1)) begin
                    q_d     = sh_nxt;
                    r_d     = rem_nxt;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter at N=8 and N=64; a monitor per instance checks every cycle
// against expectations pushed by the stimulus from a plain-arithmetic division model.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    div_iter_if #(.N(8))  b8();
    div_iter_if #(.N(64)) b64();

    div_iter #(.N(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    div_iter #(.N(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    typedef struct packed {
        logic [31:0] iss;
        logic [31:0] due;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];
    exp_t h8 = '0;
    exp_t h64 = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference: flags from the operand rules, otherwise plain integer division.
    function automatic exp_t model(input int n, input logic [63:0] dvd, input logic [31:0] dvs,
                                   input int unsigned iss);
        exp_t e;
        int h;
        logic [63:0] mask, hi, lo;
        h    = n / 2;
        mask = (64'd1 << h) - 64'd1;
        hi   = dvd >> h;
        lo   = dvd & mask;
        e     = '0;
        e.iss = iss;
        if (dvs == 32'd0) begin
            e.q = 32'(mask); e.r = 32'(lo); e.dz = 1'b1; e.due = iss + 1;
        end else if (hi >= 64'(dvs)) begin
            e.q = 32'(mask); e.r = 32'(lo); e.ovf = 1'b1; e.due = iss + 1;
        end else begin
            e.q = 32'(dvd / 64'(dvs)); e.r = 32'(dvd % 64'(dvs)); e.due = iss + 32'(h) + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) h8 = '0;
        else if (sb8.size() > 0 && cyc == sb8[0].due) begin
            chk("done8", 64'(b8.done), 64'd1);
            chk("busy8_done", 64'(b8.busy), 64'd1);
            chk("q8", 64'(b8.q), 64'(sb8[0].q));
            chk("r8", 64'(b8.r), 64'(sb8[0].r));
            chk("dz8", 64'(b8.dz), 64'(sb8[0].dz));
            chk("ovf8", 64'(b8.ovf), 64'(sb8[0].ovf));
            h8 = sb8.pop_front();
        end else begin
            chk("nodone8", 64'(b8.done), 64'd0);
            chk("busy8", 64'(b8.busy), 64'(sb8.size() > 0 && cyc > sb8[0].iss));
            chk("hold_q8", 64'(b8.q), 64'(h8.q));
            chk("hold_r8", 64'(b8.r), 64'(h8.r));
            chk("hold_fl8", 64'({b8.dz, b8.ovf}), 64'({h8.dz, h8.ovf}));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) h64 = '0;
        else if (sb64.size() > 0 && cyc == sb64[0].due) begin
            chk("done64", 64'(b64.done), 64'd1);
            chk("q64", 64'(b64.q), 64'(sb64[0].q));
            chk("r64", 64'(b64.r), 64'(sb64[0].r));
            chk("flags64", 64'({b64.dz, b64.ovf}), 64'({sb64[0].dz, sb64[0].ovf}));
            h64 = sb64.pop_front();
        end else begin
            chk("nodone64", 64'(b64.done), 64'd0);
            chk("busy64", 64'(b64.busy), 64'(sb64.size() > 0 && cyc > sb64[0].iss));
            chk("hold_q64", 64'(b64.q), 64'(h64.q));
            chk("hold_r64", 64'(b64.r), 64'(h64.r));
            chk("hold_fl64", 64'({b64.dz, b64.ovf}), 64'({h64.dz, h64.ovf}));
        end
    end

    task automatic go8(input logic [7:0] dvd, input logic [3:0] dvs);
        exp_t e;
        @(posedge clk); #1;
        b8.start = 1'b1; b8.dividend = dvd; b8.divisor = dvs;
        e = model(8, 64'(dvd), 32'(dvs), cyc);
        sb8.push_back(e);
        @(posedge clk); #1;
        b8.start = 1'b0; b8.dividend = 8'($urandom); b8.divisor = 4'($urandom);
        while (cyc < e.due) begin @(posedge clk); #1; end
    endtask

    // Optionally re-pulses start with other operands at a random busy cycle, done cycle included.
    task automatic go64(input logic [63:0] dvd, input logic [31:0] dvs, input bit rep);
        exp_t e;
        int unsigned off;
        @(posedge clk); #1;
        b64.start = 1'b1; b64.dividend = dvd; b64.divisor = dvs;
        e = model(64, dvd, dvs, cyc);
        sb64.push_back(e);
        off = $urandom_range(1, e.due - e.iss);
        while (cyc < e.due) begin
            @(posedge clk); #1;
            b64.start    = rep && (cyc == e.iss + off);
            b64.dividend = {$urandom, $urandom};
            b64.divisor  = $urandom;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, hi;
        exp_t e;
        b8.start = 1'b0;  b8.dividend = '0;  b8.divisor = '0;
        b64.start = 1'b0; b64.dividend = '0; b64.divisor = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_busy8", 64'(b8.busy), 64'd0);
        chk("rst_q8", 64'(b8.q), 64'd0);

        go8(8'd143, 4'd13);
        go8(8'd100, 4'd7);
        repeat (10) @(posedge clk);
        go8(8'hA5, 4'd0);
        go8(8'hF0, 4'd3);
        go8(8'h5A, 4'd5);
        go8(8'h4F, 4'd5);
        go8(8'hEF, 4'hF);
        go8(8'h00, 4'd1);
        for (int i = 0; i < 60; i++) go8(8'($urandom), 4'($urandom));

        // Reset during the second iteration aborts without a done pulse.
        @(posedge clk); #1;
        b8.start = 1'b1; b8.dividend = 8'd200; b8.divisor = 4'd15;
        e = model(8, 64'd200, 32'd15, cyc);
        sb8.push_back(e);
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb8.delete();
        @(posedge clk); #1;
        chk("abort_busy", 64'(b8.busy), 64'd0);
        chk("abort_done", 64'(b8.done), 64'd0);
        chk("abort_q", 64'(b8.q), 64'd0);
        chk("abort_r", 64'(b8.r), 64'd0);
        chk("abort_flags", 64'({b8.dz, b8.ovf}), 64'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        go8(8'd143, 4'd11);

        go64(64'h1234_5678_9ABC_DEF0, 32'd0, 1'b1);
        go64(64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF, 1'b1);
        go64(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            if (i % 4 == 0) begin
                a = $urandom; b = $urandom | 32'd1;
                go64(64'(a) * 64'(b), b, 1'b1);
            end else begin
                b = $urandom;
                if (b == 32'd0) b = 32'd1;
                hi = $urandom % b;
                go64({hi, $urandom}, b, 1'b1);
            end
        end
        @(posedge clk); #1;
        b64.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb8_drained", 64'(sb8.size()), 64'd0);
        chk("sb64_drained", 64'(sb64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
